// File: rtl/dp_ram_sync_if.sv
// -----------------------------------------------------------------------------
// dp_ram_sync_if
//   Bundles both ports of the dual-port RAM into one interface.
//   The signal names match the RAM's port names.
//   Signals:
//     wr_en_a / addr_a / din_a : port A write enable, word address, write data
//     dout_a                   : port A registered read data
//     wr_en_b / addr_b / din_b : port B write enable, word address, write data
//     dout_b                   : port B registered read data
//   Modports:
//     master : the user of the RAM; drives requests and receives read data
//     slave  : the RAM itself
//   Handshake: there is none. Every rising clk edge is a transaction on each
//   port. A read is always performed, and a write is added when wr_en_x=1.
//   Read data appears on dout_x one edge after the address was presented.
// -----------------------------------------------------------------------------
interface dp_ram_sync_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 12
);
   logic                  wr_en_a;
   logic [ADDR_WIDTH-1:0] addr_a;
   logic [DATA_WIDTH-1:0] din_a;
   logic [DATA_WIDTH-1:0] dout_a;
   logic                  wr_en_b;
   logic [ADDR_WIDTH-1:0] addr_b;
   logic [DATA_WIDTH-1:0] din_b;
   logic [DATA_WIDTH-1:0] dout_b;

   modport master (
      output wr_en_a, addr_a, din_a,
      output wr_en_b, addr_b, din_b,
      input  dout_a, dout_b
   );

   modport slave (
      input  wr_en_a, addr_a, din_a,
      input  wr_en_b, addr_b, din_b,
      output dout_a, dout_b
   );
endinterface

// File: rtl/dp_ram_sync.sv
// -----------------------------------------------------------------------------
// dp_ram_sync
//   True dual-port synchronous RAM. It has 2**ADDR_WIDTH words of DATA_WIDTH
//   bits, and both ports share a single clock. Each port has a 1-cycle
//   registered read. Reads are read-first on the same port and across ports.
//   When both ports write the same address in one cycle, port B wins.
//   Ports:
//     clk : single clock, rising edge
//     rst : asynchronous active-high reset. It clears dout_a/dout_b only and
//           leaves the array contents untouched.
//     bus : dp_ram_sync_if.slave, which carries the A and B request/read signals
// -----------------------------------------------------------------------------
module dp_ram_sync #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 12
) (
   input logic          clk,
   input logic          rst,
   dp_ram_sync_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   // The declaration initialiser gives the power-up contents. It becomes the
   // FPGA bitstream init and also sets the simulation start value.
   logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

   logic [DATA_WIDTH-1:0] dout_a_q;
   logic [DATA_WIDTH-1:0] dout_b_q;

   // Both writes live in one process so the array has a single driver.
   // Port B's assignment comes second, so B wins on an address collision.
   always_ff @(posedge clk) begin
      if (bus.wr_en_a) begin
         mem[bus.addr_a] <= bus.din_a;
      end
      if (bus.wr_en_b) begin
         mem[bus.addr_b] <= bus.din_b;
      end
   end

   // Reads sample mem before this edge's writes land (non-blocking update).
   // This makes both ports read-first for their own and the other port's write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_a_q <= '0;
         dout_b_q <= '0;
      end else begin
         dout_a_q <= mem[bus.addr_a];
         dout_b_q <= mem[bus.addr_b];
      end
   end

   assign bus.dout_a = dout_a_q;
   assign bus.dout_b = dout_b_q;
endmodule

// File: tb/tb_dp_ram_sync.sv
// -----------------------------------------------------------------------------
// tb_dp_ram_sync
//   Self-checking bench for dp_ram_sync.
//   - The reference model is a plain array. For each edge it looks up both
//     read addresses first and only then applies write A followed by write B.
//   - The driver sets inputs just after a falling edge and pushes the expected
//     dout_a/dout_b for the next rising edge into two queues.
//   - The monitor pops one entry from each queue on every falling edge and
//     compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_dp_ram_sync;
   localparam int DW = 8;
   localparam int AW = 12;
   localparam int DEPTH = 2 ** AW;

   logic clk;
   logic rst;

   dp_ram_sync_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

   dp_ram_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [DW-1:0] exp_a_q[$];
   logic [DW-1:0] exp_b_q[$];
   logic [DW-1:0] model_mem [DEPTH];
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [DW-1:0] act,
                        input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle(input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                        input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
      @(negedge clk);
      #1;
      bus_if.wr_en_a = wa;
      bus_if.addr_a  = aa;
      bus_if.din_a   = da;
      bus_if.wr_en_b = wb;
      bus_if.addr_b  = ab;
      bus_if.din_b   = db;
      // read-first: expected outputs are the words as they were before this edge
      exp_a_q.push_back(model_mem[aa]);
      exp_b_q.push_back(model_mem[ab]);
      if (wa) model_mem[aa] = da;
      if (wb) model_mem[ab] = db;   // B second, so B wins a collision
   endtask

   task automatic idle();
      @(negedge clk);
      #1;
      bus_if.wr_en_a = 1'b0;
      bus_if.wr_en_b = 1'b0;
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!rst && exp_a_q.size() > 0 && exp_b_q.size() > 0) begin
         check("dout_a", bus_if.dout_a, exp_a_q.pop_front());
         check("dout_b", bus_if.dout_b, exp_b_q.pop_front());
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      rst            = 1'b1;
      bus_if.wr_en_a = 1'b0;
      bus_if.addr_a  = '0;
      bus_if.din_a   = '0;
      bus_if.wr_en_b = 1'b0;
      bus_if.addr_b  = '0;
      bus_if.din_b   = '0;

      repeat (2) @(posedge clk);
      #1;
      check("reset_init_a", bus_if.dout_a, 8'h00);
      check("reset_init_b", bus_if.dout_b, 8'h00);
      @(negedge clk);
      rst = 1'b0;

      // Reset mid-operation: outputs clear at once, but the array is kept
      cycle(1'b1, 12'h010, 8'h33, 1'b0, 12'h000, 8'h00);
      cycle(1'b1, 12'h020, 8'h5A, 1'b0, 12'h000, 8'h00);
      cycle(1'b0, 12'h020, 8'h00, 1'b0, 12'h020, 8'h00);
      idle();   // the monitor has now seen 0x5A on both outputs
      #1;
      rst = 1'b1;
      #1;
      check("reset_async_a", bus_if.dout_a, 8'h00);
      check("reset_async_b", bus_if.dout_b, 8'h00);
      @(posedge clk);
      #1;
      check("reset_hold_a", bus_if.dout_a, 8'h00);
      check("reset_hold_b", bus_if.dout_b, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      cycle(1'b0, 12'h010, 8'h00, 1'b0, 12'h010, 8'h00);   // expect 0x33

      // Write on A, then read on both ports
      cycle(1'b1, 12'h123, 8'hA5, 1'b0, 12'h123, 8'h00);
      cycle(1'b0, 12'h123, 8'h00, 1'b0, 12'h123, 8'h00);

      // Read-first during a write
      cycle(1'b1, 12'h040, 8'h11, 1'b0, 12'h000, 8'h00);
      cycle(1'b1, 12'h040, 8'h22, 1'b0, 12'h040, 8'h00);
      cycle(1'b0, 12'h040, 8'h00, 1'b0, 12'h040, 8'h00);

      // Write collision: B wins
      cycle(1'b1, 12'h0F0, 8'h01, 1'b1, 12'h0F0, 8'h02);
      cycle(1'b0, 12'h0F0, 8'h00, 1'b0, 12'h0F0, 8'h00);

      // Independent ports, plus an unwritten word
      cycle(1'b1, 12'h000, 8'hAA, 1'b1, 12'hFFF, 8'h55);
      cycle(1'b0, 12'h000, 8'h00, 1'b0, 12'hFFF, 8'h00);
      cycle(1'b0, 12'h800, 8'h00, 1'b0, 12'h800, 8'h00);

      // Streaming: write 0..63 on A, then read them back-to-back on B
      for (int i = 0; i < 64; i++) cycle(1'b1, 12'(i), 8'(i), 1'b0, 12'h000, 8'h00);
      for (int i = 0; i < 64; i++) cycle(1'b0, 12'h000, 8'h00, 1'b0, 12'(i), 8'h00);

      // Random traffic, biased to a small address window to force collisions
      for (int n = 0; n < 400; n++) begin
         logic [AW-1:0] ra;
         logic [AW-1:0] rb;
         ra = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom());
         rb = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom());
         cycle(1'($urandom_range(0, 1)), ra, DW'($urandom()),
               1'($urandom_range(0, 1)), rb, DW'($urandom()));
      end

      idle();
      idle();
      check("queue_drained_a", 8'(exp_a_q.size()), 8'h00);
      check("queue_drained_b", 8'(exp_b_q.size()), 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
